seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multi-cycle radix-2 restoring divider, WIDTH-bit, signed/unsigned selectable per operation.
//  Parametrised, registered successor to the combinational 32-bit divider.
//  Sits between the ALU issue stage and writeback; one operation in flight; valid/ready both sides.
//  Adds clocking, backpressure, defined divide-by-zero and signed-overflow results.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      dividend/divisor/s valid
//  in_ready   out  1      divider can accept an operation
//  dividend   in   WIDTH  dividend
//  divisor    in   WIDTH  divisor
//  s          in   1      0 = unsigned, 1 = signed (two's complement)
//  out_valid  out  1      quotient/remainder/error valid
//  out_ready  in   1      consumer accepts result
//  quotient   out  WIDTH  quotient
//  remainder  out  WIDTH  remainder
//  error      out  1      1 = divide by zero
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; error=0; counter=0.
//  Reset mid-operation: in-flight op discarded, no result produced.
//  States: IDLE -> BUSY -> FIX -> DONE -> IDLE; IDLE -> DONE for special cases.
//  IDLE: in_ready=1. Accept on edge with in_valid=1. Latch s, sign flags, |dividend|, |divisor|
//   (magnitudes only when s=1). Clear partial remainder and counter.
//   Operand changes after accept are ignored.
//  Special cases at accept go straight to DONE (out_valid in the next cycle):
//   divisor==0 -> error=1, quotient=all ones, remainder=dividend (raw), any s.
//   s=1, dividend=MIN (1<<WIDTH-1), divisor=-1 -> quotient=MIN, remainder=0, error=0.
//  BUSY: one restoring step per edge, MSB of dividend first.
//   Step: rem={rem[WIDTH-2:0],next_bit}; trial=rem-div (WIDTH+1 bits);
//   trial>=0 -> rem=trial, q bit=1; otherwise q bit=0.
//   Exactly WIDTH edges, counter 0..WIDTH-1, then FIX.
//  FIX, one edge:
//   s=1 and sign(dividend)!=sign(divisor) -> negate quotient.
//   s=1 and dividend negative -> negate remainder.
//   Rounding toward zero; remainder takes the dividend's sign; |rem|<|divisor|.
//  Latency: out_valid rises WIDTH+2 edges after the accept edge (34 for WIDTH=32).
//   Special cases: 1 edge after accept.
//  DONE: out_valid=1; quotient, remainder and error held stable until the edge with out_ready=1.
//   Then state=IDLE, out_valid=0, and in_ready=1 in the following cycle.
//   No same-cycle accept of a new op in DONE; in_ready=0 in BUSY/FIX/DONE.
//  quotient/remainder/error registered, change only on FIX or special-case edge; error cleared on accept.
//  Dividend 0 with divisor != 0 takes the normal path: q=0, r=0.
//  All arithmetic modulo 2^WIDTH except the WIDTH+1-bit trial subtract.
// TESTING  (WIDTH=32)
//  s=0, 100/7 -> q=14, r=2, error=0; out_valid exactly 34 edges after accept.
//  s=1, -7/2 (0xFFFFFFF9/2) -> q=0xFFFFFFFD, r=0xFFFFFFFF; 7/-2 -> q=0xFFFFFFFD, r=1.
//  s=0 and s=1, 5/0 -> error=1, q=0xFFFFFFFF, r=5, out_valid 1 edge after accept; next op error=0.
//  s=1, 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0, error=0.
//  s=0, same operands -> q=0, r=0x80000000.
//  s=0, 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
//  Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored.
//  Reset: rst pulsed at BUSY edge 10 -> all outputs 0, in_ready=1; next op 9/3 -> q=3, r=0.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider, signed/unsigned per op, valid/ready on both sides
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             error
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] counter;
  logic neg_q, neg_r, div_zero, overflow, fits;
  logic [WIDTH-1:0] dvd, dvs, rem, trial;
  logic [WIDTH:0] shifted;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign div_zero = divisor == '0;
  assign overflow = s && dividend == MIN && divisor == '1;
  // shifted keeps the bit pushed out of rem so divisors above half range still compare correctly
  assign shifted = {rem, dvd[WIDTH-1]};
  assign fits = shifted >= {1'b0, dvs};
  assign trial = shifted[WIDTH-1:0] - dvs;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  // next-state: special cases bypass the iteration and go straight to DONE
  always_comb begin
    next = state;
    case (state)
      IDLE: if (in_valid) next = (div_zero || overflow) ? DONE : BUSY;
      BUSY: if (counter == CW'(WIDTH-1)) next = FIX;
      FIX: next = DONE;
      DONE: if (out_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end
  // datapath: latch magnitudes on accept, one restoring step per BUSY edge, sign fix-up in FIX
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      counter <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      quotient <= '0;
      remainder <= '0;
      error <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          neg_q <= s && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r <= s && dividend[WIDTH-1];
          dvd <= (s && dividend[WIDTH-1]) ? -dividend : dividend;
          dvs <= (s && divisor[WIDTH-1]) ? -divisor : divisor;
          rem <= '0;
          counter <= '0;
          error <= div_zero;
          if (div_zero) begin
            quotient <= '1;
            remainder <= dividend;
          end else if (overflow) begin
            quotient <= MIN;
            remainder <= '0;
          end
        end
        BUSY: begin
          rem <= fits ? trial : shifted[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], fits};
          counter <= counter + 1'b1;
        end
        FIX: begin
          quotient <= neg_q ? -dvd : dvd;
          remainder <= neg_r ? -rem : rem;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against an arithmetic reference
module tb_seq_divider;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, s = 0;
  logic in_ready, out_valid, error;
  logic [31:0] dividend = 0, divisor = 0, quotient, remainder;
  int tests = 0, fails = 0;

  typedef struct {
    logic [31:0] a, b;
    logic sg;
    logic [31:0] q, r;
    logic e;
    int lat;
  } vec_t;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .s(s), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder), .error(error)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [31:0] a, b, input logic sg,
                                output logic [31:0] q, r, output logic e, output int lat);
    int sa, sb;
    sa = a;
    sb = b;
    e = 0;
    lat = 34;
    if (b == 0) begin
      q = '1; r = a; e = 1; lat = 1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 0; lat = 1;
    end else if (sg) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // lat counts edges from the accept edge (inclusive) until out_valid is seen
  task automatic do_op(input logic [31:0] a, b, input logic sg,
                       output logic [31:0] q, r, output logic e, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    dividend = a; divisor = b; s = sg; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; dividend = $urandom; divisor = $urandom; s = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    q = quotient; r = remainder; e = error;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (quotient !== 0 || remainder !== 0) begin fails++; $display("FAIL reset_qr got %h/%h want 0/0", quotient, remainder); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error got %b want 0", error); end
  endtask

  task automatic test_directed;
    vec_t v[11] = '{
      '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34},
      '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34},
      '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 34},
      '{32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1},
      '{32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 1},
      '{32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 34},
      '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1},
      '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 34},
      '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 34},
      '{32'd0, 32'd5, 1'b1, 32'd0, 32'd0, 1'b0, 34},
      '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'd1, 1'b0, 34}
    };
    logic [31:0] q, r;
    logic e;
    int lat;
    foreach (v[i]) begin
      do_op(v[i].a, v[i].b, v[i].sg, q, r, e, lat);
      tests++; if (q !== v[i].q) begin fails++; $display("FAIL dir%0d_quotient got %h want %h", i, q, v[i].q); end
      tests++; if (r !== v[i].r) begin fails++; $display("FAIL dir%0d_remainder got %h want %h", i, r, v[i].r); end
      tests++; if (e !== v[i].e) begin fails++; $display("FAIL dir%0d_error got %b want %b", i, e, v[i].e); end
      tests++; if (lat != v[i].lat) begin fails++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, q, r, eq, er;
    logic sg, e, ee;
    int lat, el;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 100);
        default: a = $urandom;
      endcase
      sg = 1'($urandom);
      model(a, b, sg, eq, er, ee, el);
      do_op(a, b, sg, q, r, e, lat);
      tests++; if (q !== eq || r !== er || e !== ee) begin
        fails++; $display("FAIL rand%0d %h/%h s=%b got q=%h r=%h e=%b want q=%h r=%h e=%b", i, a, b, sg, q, r, e, eq, er, ee);
      end
      tests++; if (lat != el) begin fails++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, el); end
    end
  endtask

  task automatic test_backpressure;
    int w;
    bit seen;
    @(negedge clk);
    dividend = 1000; divisor = 7; s = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    w = 0;
    while (!out_valid && w < 200) begin @(posedge clk); #1; w++; end
    tests++; if (!out_valid) begin fails++; $display("FAIL bp_out_valid timeout got 0 want 1"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1; dividend = $urandom; divisor = $urandom_range(1, 9); s = 1'($urandom);
      @(posedge clk); #1;
      tests++; if (out_valid !== 1 || in_ready !== 0) begin fails++; $display("FAIL bp_hold%0d got valid=%b ready=%b want 1/0", i, out_valid, in_ready); end
      tests++; if (quotient !== 142 || remainder !== 6 || error !== 0) begin fails++; $display("FAIL bp_stable%0d got %0d/%0d/%b want 142/6/0", i, quotient, remainder, error); end
    end
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    tests++; if (out_valid !== 0 || in_ready !== 1) begin fails++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
    tests++; if (seen) begin fails++; $display("FAIL bp_ignored_pulses got out_valid=1 want 0"); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] q, r;
    logic e;
    int lat;
    bit seen;
    @(negedge clk);
    dividend = 1000; divisor = 3; s = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (10) @(posedge clk);
    #1 rst = 1;
    #1;
    tests++; if (in_ready !== 1 || out_valid !== 0) begin fails++; $display("FAIL mid_reset_hs got ready=%b valid=%b want 1/0", in_ready, out_valid); end
    tests++; if (quotient !== 0 || remainder !== 0 || error !== 0) begin fails++; $display("FAIL mid_reset_out got %h/%h/%b want 0/0/0", quotient, remainder, error); end
    @(negedge clk); rst = 0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
    tests++; if (seen) begin fails++; $display("FAIL mid_reset_discard got out_valid=1 want 0"); end
    do_op(9, 3, 0, q, r, e, lat);
    tests++; if (q !== 3 || r !== 0 || e !== 0) begin fails++; $display("FAIL mid_reset_next got %0d/%0d/%b want 3/0/0", q, r, e); end
    tests++; if (lat != 34) begin fails++; $display("FAIL mid_reset_latency got %0d want 34", lat); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_backpressure;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
